// File: rtl/encoder4to2_hs.sv
// Sequential 4-to-2 encoder: latches request lines into a pending register and drains them one index per valid/ready transfer.
// Define ENCODER_RR_EN for round-robin search order; the default build uses fixed highest-index priority. Only N=4, AW=2 is supported.
`timescale 1ns/1ps

module encoder4to2_hs #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  D,
  input  logic          E,
  input  logic          ready,
  output logic [AW-1:0] A,
  output logic          V,
  output logic          busy,
  output logic          ovf
);

  // Handshake: A is presented while V=1 and holds until an edge with V=1 && ready=1;
  // the output register reloads whenever it is empty (V=0) or being drained (ready=1).
  logic [N-1:0]  pend;
  logic [N-1:0]  clr;
  logic [N-1:0]  cap;
  logic [AW-1:0] sel;
  logic          load;

`ifdef ENCODER_RR_EN
  logic [AW-1:0] rr_ptr;
  logic [AW-1:0] rr_idx;
  logic          rr_found;

  // Search starts one past the last grant; AW-bit arithmetic wraps modulo N.
  always_comb begin
    sel      = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      rr_idx = rr_ptr + AW'(i);
      if (!rr_found && pend[rr_idx]) begin
        sel      = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= AW'(N - 1);
    end else if (load && (|pend)) begin
      rr_ptr <= sel;
    end
  end
`else
  // Ascending scan lets the highest set index win.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) sel = AW'(i);
    end
  end
`endif

  assign load = !V || ready;
  assign clr  = (load && (|pend)) ? (N'(1) << sel) : '0;
  assign cap  = E ? D : '0;
  assign busy = (|pend) | V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      A    <= '0;
      V    <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      // Capture is OR'ed after the clear so a re-request in its grant cycle survives.
      pend <= (pend & ~clr) | cap;
      if (|(cap & pend & ~clr)) ovf <= 1'b1;
      if (load) begin
        if (|pend) begin
          A <= sel;
          V <= 1'b1;
        end else begin
          V <= 1'b0;
        end
      end
    end
  end

endmodule
